// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer.
// Optional writeback-to-head bypass is enabled with the ROB_WB_BYPASS_EN macro.
package rob_pkg;

  localparam int unsigned ROB_DEPTH = 128;
  localparam int unsigned ROB_IDW   = 7;

  typedef logic [ROB_IDW:0] robid_t;
  typedef logic [5:0]       rd_t;

  typedef struct packed {
    logic        alloc;
    logic        done;
    logic        err;
    rd_t         rd;
    logic [31:0] result;
  } rob_entry_t;

endpackage

// File: rtl/rob_storage.sv
// Destination and result arrays of the reorder buffer: rename write port,
// writeback write port, asynchronous read at the head.
module rob_storage
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned IDW   = ROB_IDW
) (
  input  logic           clk_i,
  input  logic           rd_we_i,
  input  logic [IDW-1:0] rd_waddr_i,
  input  rd_t            rd_wdata_i,
  input  logic           res_we_i,
  input  logic [IDW-1:0] res_waddr_i,
  input  logic [31:0]    res_wdata_i,
  input  logic [IDW-1:0] raddr_i,
  output rd_t            rd_rdata_o,
  output logic [31:0]    res_rdata_o
);

  rd_t         rd_mem_q  [DEPTH];
  logic [31:0] res_mem_q [DEPTH];

  // Payload only; validity is tracked by the control bits in the parent.
  always_ff @(posedge clk_i) begin
    if (rd_we_i) begin
      rd_mem_q[rd_waddr_i] <= rd_wdata_i;
    end
    if (res_we_i) begin
      res_mem_q[res_waddr_i] <= res_wdata_i;
    end
  end

  assign rd_rdata_o  = rd_mem_q[raddr_i];
  assign res_rdata_o = res_mem_q[raddr_i];

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates robids, collects writebacks, retires in order and
// flushes on a faulting head. Macro ROB_WB_BYPASS_EN lets a head writeback retire a cycle early.
module rob
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned IDW   = ROB_IDW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rename_rob_valid,
  input  logic [5:0]   rename_rob_rd,
  output logic         rob_rename_ready,
  output logic [IDW:0] rob_rename_robid,
  input  logic         wb_valid,
  input  logic         wb_error,
  input  logic [IDW:0] wb_robid,
  input  logic [5:0]   wb_rd,
  input  logic [31:0]  wb_result,
  output logic         rob_ret_valid,
  output logic [4:0]   rob_ret_rd,
  output logic [31:0]  rob_ret_result,
  output logic         rob_flush
);

  localparam logic [IDW:0] FullCount = (IDW + 1)'(DEPTH);
  localparam logic [IDW:0] IdOne     = (IDW + 1)'(1);

  logic [IDW:0]   head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [DEPTH-1:0] alloc_q, alloc_d, done_q, done_d, err_q, err_d;
  logic           flush_q, flush_d;
  logic           ret_valid_q, ret_valid_d;
  logic [4:0]     ret_rd_q, ret_rd_d;
  logic [31:0]    ret_result_q, ret_result_d;

  logic [IDW-1:0] head_idx, tail_idx, wb_idx;
  logic           alloc_fire, wb_acc, head_ready, retire;
  rd_t            head_rd;
  logic [31:0]    head_result;
  rob_entry_t     head_e;

  // The wrap bit of wb_robid and the bus copy of rd carry nothing the ROB needs.
  logic unused_wb;
  assign unused_wb = ^{wb_rd, wb_robid[IDW]};

  assign head_idx = head_q[IDW-1:0];
  assign tail_idx = tail_q[IDW-1:0];
  assign wb_idx   = wb_robid[IDW-1:0];

  assign rob_rename_ready = (count_q != FullCount) & ~flush_q;
  assign rob_rename_robid = tail_q;
  assign alloc_fire       = rename_rob_valid & rob_rename_ready;
  assign wb_acc           = wb_valid & alloc_q[wb_idx] & ~flush_q;

  rob_storage #(
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) u_storage (
    .clk_i       (clk),
    .rd_we_i     (alloc_fire),
    .rd_waddr_i  (tail_idx),
    .rd_wdata_i  (rename_rob_rd),
    .res_we_i    (wb_acc),
    .res_waddr_i (wb_idx),
    .res_wdata_i (wb_result),
    .raddr_i     (head_idx),
    .rd_rdata_o  (head_rd),
    .res_rdata_o (head_result)
  );

  always_comb begin
    head_e.alloc  = alloc_q[head_idx];
    head_e.done   = done_q[head_idx];
    head_e.err    = err_q[head_idx];
    head_e.rd     = head_rd;
    head_e.result = head_result;
`ifdef ROB_WB_BYPASS_EN
    if (wb_acc && (wb_idx == head_idx)) begin
      head_e.done   = 1'b1;
      head_e.err    = wb_error;
      head_e.result = wb_result;
    end
`endif
  end

  assign head_ready = head_e.alloc & head_e.done & ~flush_q;
  assign retire     = head_ready & ~head_e.err;
  assign flush_d    = head_ready & head_e.err;

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    err_d   = err_q;
    if (flush_q) begin
      alloc_d = '0;
    end else begin
      if (wb_acc) begin
        done_d[wb_idx] = 1'b1;
        err_d[wb_idx]  = wb_error;
      end
      if (retire) begin
        alloc_d[head_idx] = 1'b0;
      end
      if (alloc_fire) begin
        alloc_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        err_d[tail_idx]   = 1'b0;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (retire) begin
        head_d = head_q + IdOne;
      end
      if (alloc_fire) begin
        tail_d = tail_q + IdOne;
      end
      case ({alloc_fire, retire})
        2'b10:   count_d = count_q + IdOne;
        2'b01:   count_d = count_q - IdOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ret_valid_d  = retire & ~head_e.rd[5];
    ret_rd_d     = ret_rd_q;
    ret_result_d = ret_result_q;
    if (retire) begin
      ret_rd_d     = head_e.rd[4:0];
      ret_result_d = head_e.result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      alloc_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
      flush_q      <= 1'b0;
      ret_valid_q  <= 1'b0;
      ret_rd_q     <= '0;
      ret_result_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      alloc_q      <= alloc_d;
      done_q       <= done_d;
      err_q        <= err_d;
      flush_q      <= flush_d;
      ret_valid_q  <= ret_valid_d;
      ret_rd_q     <= ret_rd_d;
      ret_result_q <= ret_result_d;
    end
  end

  assign rob_ret_valid  = ret_valid_q;
  assign rob_ret_rd     = ret_rd_q;
  assign rob_ret_result = ret_result_q;
  assign rob_flush      = flush_q;

endmodule
